// File: rtl/jtdsp16_rom_aau.sv
// DSP16 ROM address arithmetic unit: program counter, pt/pr/pi/i registers
// and ROM fetch address generation.
module jtdsp16_rom_aau #(
    parameter logic [15:0] IRQ_VEC = 16'h0001,
    parameter logic [15:0] RST_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        goto_ja,
    input  logic        call_ja,
    input  logic        goto_b,
    input  logic        icall,
    input  logic        ext_irq,
    input  logic        post_inc,
    input  logic        pc_halt,
    input  logic        xaau_imm_load,
    input  logic        xaau_ram_load,
    input  logic [2:0]  r_field,
    input  logic [11:0] i_field,
    input  logic [15:0] long_imm,
    input  logic [15:0] ram_dout,
    output logic [15:0] rom_addr,
    output logic [15:0] pt,
    output logic [15:0] pr,
    output logic [15:0] pi,
    output logic [11:0] i_reg,
    output logic        in_irq
);

    logic [15:0] pc;
    logic [15:0] pc_nxt;
    logic        pr_save;
    logic        irq_nxt;
    logic        irq_take;
    logic [2:0]  b_code;
    logic        ld;
    logic [15:0] ld_data;
    logic [15:0] pt_inc;

    assign rom_addr = pc;
    assign irq_take = icall & ext_irq & ~in_irq;
    assign b_code   = i_field[10:8];
    assign ld       = xaau_imm_load | xaau_ram_load;
    assign ld_data  = xaau_imm_load ? long_imm : ram_dout;
    assign pt_inc   = pt + {{4{i_reg[11]}}, i_reg};

    always_comb begin
        pc_nxt  = pc + 16'd1;
        pr_save = 1'b0;
        irq_nxt = in_irq;
        if (irq_take) begin
            pc_nxt  = IRQ_VEC;
            irq_nxt = 1'b1;
        end else if (goto_b) begin
            unique case (b_code)
                3'b000: pc_nxt = pr;
                3'b001: begin
                    pc_nxt  = pi;
                    irq_nxt = 1'b0;
                end
                3'b010: pc_nxt = pt;
                3'b011: begin
                    pc_nxt  = pt;
                    pr_save = 1'b1;
                end
                default: pc_nxt = pc + 16'd1;
            endcase
        end else if (call_ja) begin
            pc_nxt  = {pc[15:12], i_field};
            pr_save = 1'b1;
        end else if (goto_ja) begin
            pc_nxt = {pc[15:12], i_field};
        end else if (pc_halt) begin
            pc_nxt = pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RST_PC;
            in_irq <= 1'b0;
        end else if (cen) begin
            pc     <= pc_nxt;
            in_irq <= irq_nxt;
        end
    end

    // Flow-control saves of the return address win over register loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pt    <= 16'd0;
            pr    <= 16'd0;
            pi    <= 16'd0;
            i_reg <= 12'd0;
        end else if (cen) begin
            if (ld && r_field == 3'd0)
                pt <= ld_data;
            else if (post_inc)
                pt <= pt_inc;
            if (pr_save)
                pr <= pc;
            else if (ld && r_field == 3'd1)
                pr <= ld_data;
            if (irq_take)
                pi <= pc;
            else if (ld && r_field == 3'd2)
                pi <= ld_data;
            if (ld && r_field == 3'd3)
                i_reg <= ld_data[11:0];
        end
    end

endmodule

// File: tb/tb_jtdsp16_rom_aau.sv
// Directed scoreboard bench for jtdsp16_rom_aau.
module tb_jtdsp16_rom_aau;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        goto_ja, call_ja, goto_b, icall, ext_irq;
    logic        post_inc, pc_halt, xaau_imm_load, xaau_ram_load;
    logic [2:0]  r_field;
    logic [11:0] i_field;
    logic [15:0] long_imm, ram_dout;
    logic [15:0] rom_addr, pt, pr, pi;
    logic [11:0] i_reg;
    logic        in_irq;

    int n_eval = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    localparam int ROM = 0, PT = 1, PR = 2, PI = 3, IR = 4, IRQ = 5;

    jtdsp16_rom_aau dut (
        .clk(clk), .rst(rst), .cen(cen),
        .goto_ja(goto_ja), .call_ja(call_ja), .goto_b(goto_b),
        .icall(icall), .ext_irq(ext_irq), .post_inc(post_inc),
        .pc_halt(pc_halt), .xaau_imm_load(xaau_imm_load),
        .xaau_ram_load(xaau_ram_load), .r_field(r_field),
        .i_field(i_field), .long_imm(long_imm), .ram_dout(ram_dout),
        .rom_addr(rom_addr), .pt(pt), .pr(pr), .pi(pi),
        .i_reg(i_reg), .in_irq(in_irq)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] obs(int sel);
        case (sel)
            ROM:     return rom_addr;
            PT:      return pt;
            PR:      return pr;
            PI:      return pi;
            IR:      return {4'd0, i_reg};
            default: return {15'd0, in_irq};
        endcase
    endfunction

    task automatic expect_v(string tag, int sel, logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [15:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            n_eval++;
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic clr();
        goto_ja = 0; call_ja = 0; goto_b = 0; icall = 0; ext_irq = 0;
        post_inc = 0; pc_halt = 0; xaau_imm_load = 0; xaau_ram_load = 0;
        r_field = 0; i_field = 0; long_imm = 0; ram_dout = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
        clr();
    endtask

    task automatic imm(logic [2:0] r, logic [15:0] d);
        xaau_imm_load = 1;
        r_field = r;
        long_imm = d;
    endtask

    task automatic expect_zero(string tag);
        expect_v({tag, "_pc"}, ROM, 16'h0000);
        expect_v({tag, "_pt"}, PT, 16'h0000);
        expect_v({tag, "_pr"}, PR, 16'h0000);
        expect_v({tag, "_pi"}, PI, 16'h0000);
        expect_v({tag, "_i"}, IR, 16'h0000);
        expect_v({tag, "_irq"}, IRQ, 16'h0000);
    endtask

    initial begin
        clr();
        rst = 1;
        cen = 0;
        #2;
        expect_zero("rst");
        drain();
        @(posedge clk);
        #1;
        rst = 0;
        cen = 1;

        for (int k = 1; k <= 5; k++) begin
            expect_v("seq", ROM, 16'(k));
            tick();
        end
        cen = 0;
        for (int k = 0; k < 3; k++) begin
            goto_ja = 1; call_ja = 1; post_inc = 1; i_field = 12'hABC;
            imm(3'd3, 16'h0123);
            expect_v("cen0_pc", ROM, 16'h0005);
            expect_v("cen0_pr", PR, 16'h0000);
            expect_v("cen0_i", IR, 16'h0000);
            tick();
        end
        cen = 1;

        imm(3'd0, 16'h3456);
        expect_v("ldpt", PT, 16'h3456);
        expect_v("ldpt_pc", ROM, 16'h0006);
        tick();
        goto_b = 1; i_field = 12'h200;
        expect_v("gotopt", ROM, 16'h3456);
        tick();
        call_ja = 1; i_field = 12'h0AB;
        expect_v("call_pr", PR, 16'h3456);
        expect_v("call_pc", ROM, 16'h30AB);
        tick();
        goto_b = 1; i_field = 12'h000;
        expect_v("return", ROM, 16'h3456);
        tick();

        imm(3'd3, 16'h0FFE);
        expect_v("ld_i", IR, 16'h0FFE);
        tick();
        imm(3'd0, 16'h0001);
        expect_v("ld_pt1", PT, 16'h0001);
        tick();
        post_inc = 1;
        expect_v("pinc1", PT, 16'hFFFF);
        tick();
        post_inc = 1;
        expect_v("pinc2", PT, 16'hFFFD);
        tick();
        post_inc = 1;
        expect_v("pinc3", PT, 16'hFFFB);
        tick();
        imm(3'd0, 16'h1000); post_inc = 1;
        expect_v("ld_beats_inc", PT, 16'h1000);
        tick();
        imm(3'd3, 16'h0002); post_inc = 1;
        expect_v("inc_old_i", PT, 16'h0FFE);
        expect_v("inc_new_i", IR, 16'h0002);
        tick();

        imm(3'd0, 16'h0200);
        tick();
        goto_b = 1; i_field = 12'h200;
        expect_v("goto200", ROM, 16'h0200);
        tick();
        icall = 1; ext_irq = 1; goto_ja = 1; i_field = 12'hFFF;
        expect_v("irq_pi", PI, 16'h0200);
        expect_v("irq_pc", ROM, 16'h0001);
        expect_v("irq_flag", IRQ, 16'h0001);
        tick();
        icall = 1; ext_irq = 1;
        expect_v("irq2_pc", ROM, 16'h0002);
        expect_v("irq2_pi", PI, 16'h0200);
        tick();
        goto_b = 1; i_field = 12'h100;
        expect_v("iret_pc", ROM, 16'h0200);
        expect_v("iret_flag", IRQ, 16'h0000);
        tick();
        icall = 1;
        expect_v("icall_noext_pc", ROM, 16'h0201);
        expect_v("icall_noext_flag", IRQ, 16'h0000);
        tick();
        goto_b = 1; i_field = 12'h100;
        expect_v("iret_idle_pc", ROM, 16'h0200);
        expect_v("iret_idle_flag", IRQ, 16'h0000);
        tick();

        imm(3'd0, 16'h0050);
        tick();
        goto_b = 1; i_field = 12'h200;
        expect_v("goto50", ROM, 16'h0050);
        tick();
        pc_halt = 1;
        expect_v("halt1", ROM, 16'h0050);
        tick();
        pc_halt = 1;
        expect_v("halt2", ROM, 16'h0050);
        tick();
        expect_v("unhalt", ROM, 16'h0051);
        tick();
        imm(3'd0, 16'hFFFF);
        tick();
        goto_b = 1; i_field = 12'h200;
        expect_v("gotoffff", ROM, 16'hFFFF);
        tick();
        expect_v("wrap", ROM, 16'h0000);
        tick();

        call_ja = 1; i_field = 12'h123;
        xaau_ram_load = 1; r_field = 3'd1; ram_dout = 16'hBEEF;
        expect_v("call_vs_ld_pr", PR, 16'h0000);
        expect_v("call_vs_ld_pc", ROM, 16'h0123);
        tick();
        xaau_ram_load = 1; r_field = 3'd1; ram_dout = 16'hBEEF;
        expect_v("ram_pr", PR, 16'hBEEF);
        tick();
        imm(3'd2, 16'h5555);
        xaau_ram_load = 1; ram_dout = 16'h1234;
        expect_v("imm_over_ram", PI, 16'h5555);
        tick();
        imm(3'd5, 16'hAAAA);
        goto_b = 1; i_field = 12'h400;
        expect_v("rsvd_pc", ROM, 16'h0126);
        expect_v("r5_pt", PT, 16'hFFFF);
        expect_v("r5_pr", PR, 16'hBEEF);
        expect_v("r5_pi", PI, 16'h5555);
        expect_v("r5_i", IR, 16'h0002);
        tick();

        #2;
        rst = 1;
        #1;
        expect_zero("midrst");
        drain();
        @(posedge clk);
        #1;
        rst = 0;
        expect_v("restart", ROM, 16'h0001);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_eval, n_fail);
        $finish;
    end

endmodule

// File: doc/jtdsp16_rom_aau.md
Name: jtdsp16_rom_aau

Overview:
- ROM address arithmetic unit (XAAU) of the DSP16 core.
- Consumes the flow-control and load strobes produced by the instruction decoder.
- Owns the program counter and the pt, pr, pi and i registers, and drives the ROM fetch address.
- Handles sequential fetch, goto/call JA, B-group jumps/returns, interrupt entry/return, pt post-increment and immediate/RAM loads into its registers.

Parameters:
- IRQ_VEC, 16'h0001, PC value loaded on interrupt entry.
- RST_PC, 16'h0000, PC value after reset.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- cen  input  1  clock enable; all state updates only when cen=1
- goto_ja  input  1  goto JA strobe
- call_ja  input  1  call JA strobe
- goto_b  input  1  B-group strobe; B code taken from i_field[10:8]
- icall  input  1  interrupt-entry strobe
- ext_irq  input  1  external IRQ request; qualifies icall
- post_inc  input  1  pt post-increment strobe
- pc_halt  input  1  hold PC this cycle
- xaau_imm_load  input  1  load register selected by r_field from long_imm
- xaau_ram_load  input  1  load register selected by r_field from ram_dout
- r_field  input  3  register select: 0=pt, 1=pr, 2=pi, 3=i, 4-7 no destination
- i_field  input  12  JA target / B field source
- long_imm  input  16  immediate data word
- ram_dout  input  16  RAM read data
- rom_addr  output  16  ROM fetch address (equals pc)
- pt  output  16  table pointer
- pr  output  16  subroutine return register
- pi  output  16  interrupt return register
- i_reg  output  12  pt increment
- in_irq  output  1  inside an interrupt service routine

Behaviour:
- Reset (async): pc=RST_PC, pt=0, pr=0, pi=0, i_reg=0, in_irq=0. Reset mid-operation aborts any flow change immediately. Fetch resumes from RST_PC on the first cen after rst falls.
- All registers update on posedge clk with cen=1. With cen=0 everything holds, and strobes are ignored even if asserted.
- rom_addr is pc, registered, with no combinational path from inputs.
- PC next-state priority, highest first:
  - icall && ext_irq && !in_irq: pi<=pc, pc<=IRQ_VEC, in_irq<=1.
  - goto_b with i_field[10:8]:
    - 000 return: pc<=pr.
    - 001 ireturn: pc<=pi, in_irq<=0.
    - 010 goto pt: pc<=pt.
    - 011 call pt: pr<=pc, pc<=pt.
    - 1xx reserved: pc<=pc+1.
  - call_ja: pr<=pc, pc<={pc[15:12], i_field}.
  - goto_ja: pc<={pc[15:12], i_field}.
  - pc_halt: pc holds.
  - otherwise: pc<=pc+1, modulo 2^16 (0xFFFF wraps to 0x0000).
- Return address saved in pr/pi is the current pc value at the strobe. The decoder discards the word fetched in the slot after a two-word instruction.
- icall while in_irq=1, or icall without ext_irq, has no effect on pc/pi; PC follows the lower priorities.
- ireturn while in_irq=0: pc<=pi, and in_irq stays 0.
- Register loads: xaau_imm_load (data long_imm) has priority over xaau_ram_load (ram_dout).
  - Destinations pt, pr and pi take all 16 bits.
  - i_reg takes data[11:0].
  - r_field 4-7: no change.
- post_inc: pt<=pt+sign_extend(i_reg), 16-bit wrap.
- Same-cycle conflicts:
  - A flow write to pr/pi (call/icall) beats a load to the same register.
  - A load to pt beats post_inc.
  - A load to i_reg with post_inc in the same cycle: increment uses the old i_reg.
- Simultaneous flow strobes resolve strictly by the priority list above.

Test Plan:
- Reset, cen=1 for 5 cycles, no strobes -> rom_addr 0,1,2,3,4. Toggle cen=0 for 3 cycles -> rom_addr holds at 5.
- pc=0x3456, call_ja with i_field=0x0AB -> pr=0x3456, rom_addr=0x30AB. Then goto_b B=000 -> rom_addr=0x3456.
- xaau_imm_load r_field=3 long_imm=0x0FFE (i=-2), imm load pt=0x0001, three post_inc -> pt=0xFFFF,0xFFFD,0xFFFB. Same cycle: load pt=0x1000 + post_inc -> pt=0x1000.
- pc=0x0200, icall+ext_irq -> pi=0x0200, rom_addr=0x0001, in_irq=1. Second icall -> ignored, pc increments. goto_b B=001 -> rom_addr=0x0200, in_irq=0.
- pc_halt asserted 2 cycles at pc=0x0050 -> rom_addr stays 0x0050, then 0x0051. pc=0xFFFF -> next rom_addr=0x0000.
- call_ja and xaau_ram_load r_field=1 (ram_dout=0xBEEF) same cycle -> pr=old pc, not 0xBEEF. Assert rst mid-sequence -> all outputs zero immediately.
